fp_div_seq: RTL and testbench
=============================

Name: fp_div_seq

Overview:
- Sequential IEEE-754-style floating-point divider, parametrised in exponent and fraction width.
- Restoring division, one quotient bit per clock; round-to-nearest-even; full special-case handling; exception flags.
- Sits beside the combinational FPU ops as the low-area divide unit.
- Uses valid/ready handshakes on input and output so the FPU issue logic can stall on it.

Parameters:
- EXP_W, 8, exponent field width; BIAS = 2^(EXP_W-1)-1 is derived internally.
- MAN_W, 23, stored fraction width; total word width W = 1+EXP_W+MAN_W.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  operands present
- in_ready  out  1  divider idle, can accept
- a  in  W  dividend {sign, exp, frac}
- b  in  W  divisor {sign, exp, frac}
- out_valid  out  1  result present
- out_ready  in  1  consumer takes result
- result  out  W  quotient a/b
- flags  out  5  {invalid, div_by_zero, overflow, underflow, inexact}

Behaviour:
- Reset (rst_n=0 at a clk edge) forces:
  - state IDLE, in_ready=1, out_valid=0, result=0, flags=0.
  - Reset mid-operation aborts the division; no output is produced.
- Accept: on an edge with in_valid && in_ready, latch a and b; in_ready=0 from then until the output handshake completes.
- States:
  - IDLE -> SPEC if the operands form a special case, else IDLE -> DIV.
  - DIV: MAN_W+3 cycles -> RND.
  - RND: 1 cycle -> DONE.
  - SPEC: 0 extra cycles -> DONE.
  - DONE -> IDLE on out_valid && out_ready.
- Latency, with k = accept edge:
  - Normal operands: out_valid rises at edge k+MAN_W+5 (28 for defaults).
  - Special cases: out_valid rises at edge k+1.
- Output hold: result and flags stay stable while out_valid=1 && out_ready=0.
- in_ready returns to 1 on the edge after the output handshake. A new operand pair cannot be accepted in the same cycle as the output handshake.
- Inputs are DAZ: exp=0 is treated as signed zero regardless of fraction.
- Sign: sign = sa^sb for every result except NaN.
- Specials, in priority order:
  1. Either operand NaN, 0/0, or inf/inf: result = +qNaN {0, all-ones exponent, 1, zeros}; invalid=1.
  2. Finite/0: result = signed inf; div_by_zero=1.
  3. inf/finite: result = signed inf; no flags.
  4. 0/finite or finite/inf: result = signed zero; no flags.
- Datapath:
  - Mantissas ma = {1, fa}, mb = {1, fb}.
  - Remainder register is MAN_W+2 bits. Each DIV cycle: trial subtract mb from the shifted remainder; if non-negative keep it and set the quotient bit to 1, else restore and set the bit to 0.
  - Q is MAN_W+3 bits with value floor(ma*2^(MAN_W+2)/mb).
- Exponent: e = ea - eb + BIAS, held as a signed EXP_W+2-bit value.
- Normalise:
  - If Q[MAN_W+2]=1: fraction = Q[MAN_W+1:2], guard = Q[1], sticky = Q[0] | (rem != 0).
  - Else: fraction = Q[MAN_W:1], guard = Q[0], sticky = (rem != 0), and e = e-1.
- Rounding: round up if guard && (sticky || fraction LSB). inexact = guard | sticky.
  - Carry out of the fraction: fraction = 0, e = e+1.
- Overflow: e >= 2^EXP_W-1 after rounding gives signed inf; overflow=1, inexact=1.
- Underflow: e <= 0 after rounding gives signed zero (flush, no subnormal output); underflow=1, inexact=1.

Test Plan:
- 6.0/2.0: a=0x40C00000, b=0x40000000 -> result=0x40400000, flags=0, out_valid exactly 28 cycles after accept.
- 1.0/3.0: a=0x3F800000, b=0x40400000 -> result=0x3EAAAAAB, flags=0b00001 (inexact); also -1.0/3.0 (0xBF800000) -> 0xBEAAAAAB.
- Specials, each out_valid 1 cycle after accept:
  - -1.0/+0 (0xBF800000/0x00000000) -> 0xFF800000, flags=0b01000.
  - 0/0 -> 0x7FC00000, flags=0b10000.
  - 0x7F800000/0x7F800000 -> 0x7FC00000, flags=0b10000.
- Range limits:
  - 0x7F000000/0x3E800000 -> 0x7F800000, flags=0b00101.
  - 0x00800000/0x40000000 -> 0x00000000, flags=0b00011.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> result/flags constant, in_ready=0, in_valid pulses ignored. Then out_ready=1 -> in_ready=1 on the next edge.
- Reset abort: drop rst_n for one edge 5 cycles into DIV -> next cycle out_valid=0, in_ready=1, and no result ever appears. A following 6.0/2.0 completes correctly.

Source files
------------

// File: rtl/fp_div_seq_if.sv
// Operand/result handshake bundle for the sequential FP divider.
// The bench drives the master side; the divider sits on the slave side.
interface fp_div_seq_if #(
   parameter int unsigned W = 32
);
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic [4:0]   flags;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, result, flags
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, result, flags
   );
endinterface

// File: rtl/fp_div_seq.sv
// Low-area floating-point divider: restoring division, one quotient bit per
// clock, round-to-nearest-even, flush-to-zero, valid/ready on both sides.
module fp_div_seq #(
   parameter int unsigned EXP_W = 8,
   parameter int unsigned MAN_W = 23
) (
   input logic        clk,
   input logic        rst_n,
   fp_div_seq_if.slave bus
);
   localparam int unsigned W    = 1 + EXP_W + MAN_W;
   localparam int unsigned BIAS = (1 << (EXP_W - 1)) - 1;
   localparam int unsigned EMAX = (1 << EXP_W) - 1;
   localparam int unsigned EW   = EXP_W + 2;
   localparam int unsigned QW   = MAN_W + 3;
   localparam int unsigned RW   = MAN_W + 2;
   localparam int unsigned CW   = $clog2(QW + 1);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      SPEC = 3'd1,
      DIV  = 3'd2,
      RND  = 3'd3,
      DONE = 3'd4
   } state_t;

   function automatic logic [EXP_W-1:0] exp_of(input logic [W-1:0] x);
      return x[W-2 -: EXP_W];
   endfunction

   function automatic logic [MAN_W-1:0] frac_of(input logic [W-1:0] x);
      return x[MAN_W-1:0];
   endfunction

   // Denormal inputs are treated as zero, so only the exponent matters here.
   function automatic logic is_zero(input logic [W-1:0] x);
      return exp_of(x) == '0;
   endfunction

   function automatic logic is_inf(input logic [W-1:0] x);
      return (exp_of(x) == {EXP_W{1'b1}}) && (frac_of(x) == '0);
   endfunction

   function automatic logic is_nan(input logic [W-1:0] x);
      return (exp_of(x) == {EXP_W{1'b1}}) && (frac_of(x) != '0);
   endfunction

   state_t          state;
   logic [W-1:0]    a_q;
   logic [W-1:0]    b_q;
   logic            sign_q;
   logic [RW-1:0]   rem_q;
   logic [QW-1:0]   quo_q;
   logic [EW-1:0]   exp_q;
   logic [CW-1:0]   cnt_q;

   logic            special_c;
   logic [W-1:0]    spec_res;
   logic [4:0]      spec_flg;
   logic [MAN_W:0]  ma_c;
   logic [MAN_W:0]  mb_c;
   logic [RW:0]     diff_c;
   logic            qbit_c;
   logic [RW-1:0]   keep_c;
   logic [MAN_W-1:0] frac_n;
   logic            guard_n;
   logic            sticky_n;
   logic [EW-1:0]   exp_n;
   logic            rnd_up;
   logic [MAN_W:0]  frac_sum;
   logic [EW-1:0]   exp_r;
   logic [W-1:0]    rnd_res;
   logic [4:0]      rnd_flg;

   assign special_c = is_zero(bus.a) | is_inf(bus.a) | is_nan(bus.a) |
                      is_zero(bus.b) | is_inf(bus.b) | is_nan(bus.b);

   // Special-case result, resolved in priority order from the latched operands.
   always_comb begin
      spec_res = '0;
      spec_flg = '0;
      if (is_nan(a_q) || is_nan(b_q) || (is_zero(a_q) && is_zero(b_q)) ||
          (is_inf(a_q) && is_inf(b_q))) begin
         spec_res = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
         spec_flg = 5'b10000;
      end else if (is_zero(b_q) && !is_inf(a_q)) begin
         spec_res = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         spec_flg = 5'b01000;
      end else if (is_inf(a_q)) begin
         spec_res = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end else begin
         spec_res = {sign_q, {(W-1){1'b0}}};
      end
   end

   // One restoring step: trial subtract, keep on non-negative.
   always_comb begin
      ma_c   = {1'b1, frac_of(a_q)};
      mb_c   = {1'b1, frac_of(b_q)};
      diff_c = {1'b0, rem_q} - {2'b00, mb_c};
      qbit_c = ~diff_c[RW];
      keep_c = qbit_c ? diff_c[RW-1:0] : rem_q;
   end

   // Normalise, round to nearest even, then clamp to inf or flush to zero.
   always_comb begin
      if (quo_q[QW-1]) begin
         frac_n   = quo_q[QW-2:2];
         guard_n  = quo_q[1];
         sticky_n = quo_q[0] | (rem_q != '0);
         exp_n    = exp_q;
      end else begin
         frac_n   = quo_q[MAN_W:1];
         guard_n  = quo_q[0];
         sticky_n = (rem_q != '0);
         exp_n    = exp_q - EW'(1);
      end
      rnd_up   = guard_n & (sticky_n | frac_n[0]);
      frac_sum = {1'b0, frac_n} + (MAN_W+1)'(rnd_up);
      exp_r    = frac_sum[MAN_W] ? exp_n + EW'(1) : exp_n;
      rnd_res  = {sign_q, exp_r[EXP_W-1:0], frac_sum[MAN_W-1:0]};
      rnd_flg  = {4'b0000, guard_n | sticky_n};
      if (!exp_r[EW-1] && (exp_r >= EW'(EMAX))) begin
         rnd_res = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         rnd_flg = 5'b00101;
      end else if (exp_r[EW-1] || (exp_r == '0)) begin
         rnd_res = {sign_q, {(W-1){1'b0}}};
         rnd_flg = 5'b00011;
      end
   end

   // Control FSM and datapath registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= IDLE;
         bus.in_ready  <= 1'b1;
         bus.out_valid <= 1'b0;
         bus.result    <= '0;
         bus.flags     <= '0;
         cnt_q         <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid && bus.in_ready) begin
                  a_q          <= bus.a;
                  b_q          <= bus.b;
                  sign_q       <= bus.a[W-1] ^ bus.b[W-1];
                  cnt_q        <= '0;
                  bus.in_ready <= 1'b0;
                  state        <= special_c ? SPEC : DIV;
               end
            end
            SPEC: begin
               bus.result    <= spec_res;
               bus.flags     <= spec_flg;
               bus.out_valid <= 1'b1;
               state         <= DONE;
            end
            DIV: begin
               // First DIV cycle seeds remainder and exponent; the rest retire one bit each.
               if (cnt_q == '0) begin
                  rem_q <= RW'(ma_c);
                  quo_q <= '0;
                  exp_q <= EW'(exp_of(a_q)) - EW'(exp_of(b_q)) + EW'(BIAS);
               end else begin
                  rem_q <= RW'({keep_c, 1'b0});
                  quo_q <= {quo_q[QW-2:0], qbit_c};
               end
               cnt_q <= cnt_q + CW'(1);
               if (cnt_q == CW'(QW)) begin
                  state <= RND;
               end
            end
            RND: begin
               bus.result    <= rnd_res;
               bus.flags     <= rnd_flg;
               bus.out_valid <= 1'b1;
               state         <= DONE;
            end
            DONE: begin
               if (bus.out_ready) begin
                  bus.out_valid <= 1'b0;
                  bus.in_ready  <= 1'b1;
                  state         <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fp_div_seq.sv
// Self-checking bench for fp_div_seq: directed cases, backpressure, reset
// abort and randomized operands against an exact-arithmetic reference.
module tb_fp_div_seq;
   localparam int unsigned EXP_W = 8;
   localparam int unsigned MAN_W = 23;
   localparam int unsigned W     = 32;
   localparam int          LAT   = MAN_W + 5;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   fp_div_seq_if #(.W(W)) bus ();

   fp_div_seq #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: exact long division with plenty of spare bits, then RNE.
   task automatic ref_div(input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output logic [4:0] fl, output bit spec);
      int ea, eb, e, m;
      bit za, zb, ia, ib, na, nb, sgn, g, s;
      logic [23:0] ma, mb;
      logic [63:0] num, q, r;
      logic [22:0] frac;
      ea  = int'(a[30:23]);
      eb  = int'(b[30:23]);
      za  = (ea == 0);
      zb  = (eb == 0);
      ia  = (ea == 255) && (a[22:0] == 0);
      ib  = (eb == 255) && (b[22:0] == 0);
      na  = (ea == 255) && (a[22:0] != 0);
      nb  = (eb == 255) && (b[22:0] != 0);
      sgn = a[31] ^ b[31];
      spec = za || zb || ia || ib || na || nb;
      fl  = 5'b00000;
      res = 32'h0;
      if (na || nb || (za && zb) || (ia && ib)) begin
         res = 32'h7FC00000;
         fl  = 5'b10000;
      end else if (zb && !ia) begin
         res = {sgn, 8'hFF, 23'h0};
         fl  = 5'b01000;
      end else if (ia) begin
         res = {sgn, 8'hFF, 23'h0};
      end else if (spec) begin
         res = {sgn, 31'h0};
      end else begin
         ma  = {1'b1, a[22:0]};
         mb  = {1'b1, b[22:0]};
         num = 64'(ma) << 39;
         q   = num / 64'(mb);
         r   = num % 64'(mb);
         if (ma >= mb) begin
            frac = q[38:16];
            g    = q[15];
            s    = (q[14:0] != 0) || (r != 0);
            e    = ea - eb + 127;
         end else begin
            frac = q[37:15];
            g    = q[14];
            s    = (q[13:0] != 0) || (r != 0);
            e    = ea - eb + 126;
         end
         m = int'(frac) + ((g && (s || frac[0])) ? 1 : 0);
         if (m == (1 << 23)) begin
            m = 0;
            e = e + 1;
         end
         if (e >= 255) begin
            res = {sgn, 8'hFF, 23'h0};
            fl  = 5'b00101;
         end else if (e <= 0) begin
            res = {sgn, 31'h0};
            fl  = 5'b00011;
         end else begin
            res = {sgn, 8'(e), 23'(m)};
            fl  = {4'b0000, g | s};
         end
      end
   endtask

   task automatic wait_out(output int n);
      n = 0;
      while (!bus.out_valid && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   // Full transaction: accept, latency, result/flags, handshake, ready return.
   task automatic do_op(input logic [31:0] av, input logic [31:0] bv, input string tag);
      logic [31:0] er;
      logic [4:0]  ef;
      bit          sp;
      int          n;
      ref_div(av, bv, er, ef, sp);
      bus.a        = av;
      bus.b        = bv;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      wait_out(n);
      check({tag, " latency"}, 64'(n), sp ? 64'd1 : 64'(LAT));
      check({tag, " result"}, 64'(bus.result), 64'(er));
      check({tag, " flags"}, 64'(bus.flags), 64'(ef));
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      check({tag, " in_ready back"}, 64'(bus.in_ready), 64'd1);
      check({tag, " out_valid drop"}, 64'(bus.out_valid), 64'd0);
   endtask

   function automatic logic [31:0] rand_op();
      logic [7:0]  e;
      logic [22:0] f;
      int          sel;
      sel = $urandom_range(0, 11);
      f   = 23'($urandom);
      case (sel)
         0: e = 8'h00;
         1: begin
            e = 8'hFF;
            if ($urandom_range(0, 1) == 0) f = '0;
         end
         2: e = 8'($urandom_range(1, 4));
         3: e = 8'($urandom_range(250, 254));
         default: e = 8'($urandom_range(1, 254));
      endcase
      return {1'($urandom), e, f};
   endfunction

   logic [31:0] dir_a [8] = '{32'h40C00000, 32'h3F800000, 32'hBF800000, 32'hBF800000,
                              32'h00000000, 32'h7F800000, 32'h7F000000, 32'h00800000};
   logic [31:0] dir_b [8] = '{32'h40000000, 32'h40400000, 32'h40400000, 32'h00000000,
                              32'h00000000, 32'h7F800000, 32'h3E800000, 32'h40000000};
   logic [31:0] dir_r [8] = '{32'h40400000, 32'h3EAAAAAB, 32'hBEAAAAAB, 32'hFF800000,
                              32'h7FC00000, 32'h7FC00000, 32'h7F800000, 32'h00000000};
   logic [4:0]  dir_f [8] = '{5'b00000, 5'b00001, 5'b00001, 5'b01000,
                              5'b10000, 5'b10000, 5'b00101, 5'b00011};
   int          dir_l [8] = '{LAT, LAT, LAT, 1, 1, 1, LAT, LAT};

   initial begin
      int n;
      int seen;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset in_ready", 64'(bus.in_ready), 64'd1);
      check("reset out_valid", 64'(bus.out_valid), 64'd0);
      check("reset result", 64'(bus.result), 64'd0);
      check("reset flags", 64'(bus.flags), 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed cases with spec-given expectations.
      for (int i = 0; i < 8; i++) begin
         bus.a        = dir_a[i];
         bus.b        = dir_b[i];
         bus.in_valid = 1'b1;
         @(posedge clk); #1;
         bus.in_valid = 1'b0;
         check($sformatf("dir%0d in_ready low", i), 64'(bus.in_ready), 64'd0);
         wait_out(n);
         check($sformatf("dir%0d latency", i), 64'(n), 64'(dir_l[i]));
         check($sformatf("dir%0d result", i), 64'(bus.result), 64'(dir_r[i]));
         check($sformatf("dir%0d flags", i), 64'(bus.flags), 64'(dir_f[i]));
         bus.out_ready = 1'b1;
         @(posedge clk); #1;
         bus.out_ready = 1'b0;
         check($sformatf("dir%0d in_ready back", i), 64'(bus.in_ready), 64'd1);
      end

      // Backpressure: output held, new operands ignored.
      bus.a        = 32'h40C00000;
      bus.b        = 32'h40000000;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      wait_out(n);
      check("bp latency", 64'(n), 64'(LAT));
      for (int i = 0; i < 10; i++) begin
         bus.in_valid = 1'(i % 2);
         bus.a        = 32'h3F800000;
         bus.b        = 32'h00000000;
         @(posedge clk); #1;
         check("bp result hold", 64'(bus.result), 64'h40400000);
         check("bp flags hold", 64'(bus.flags), 64'd0);
         check("bp in_ready", 64'(bus.in_ready), 64'd0);
         check("bp out_valid", 64'(bus.out_valid), 64'd1);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      check("bp in_ready back", 64'(bus.in_ready), 64'd1);
      @(posedge clk); #1;
      check("bp no stray accept", 64'(bus.in_ready), 64'd1);

      // Reset part-way through the divide.
      bus.a        = 32'h40C00000;
      bus.b        = 32'h40000000;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      check("abort out_valid", 64'(bus.out_valid), 64'd0);
      check("abort in_ready", 64'(bus.in_ready), 64'd1);
      seen = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (bus.out_valid) seen++;
      end
      check("abort no result", 64'(seen), 64'd0);
      do_op(32'h40C00000, 32'h40000000, "after abort");

      // Randomized operands against the reference.
      for (int i = 0; i < 150; i++) begin
         do_op(rand_op(), rand_op(), $sformatf("rnd%0d", i));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
